// File: rtl/key_debounce.sv
// key_debounce
//   Cleans up the raw {number, buttonPressed} stream from the keypad decoder.
//   Each physical key press produces exactly one keyValid pulse with a stable
//   keyCode. Bounce, chatter, key changes while a key is held, and held keys
//   never produce extra events.
//
// Ports
//   clock1000     in   1  system clock (1 kHz), the only clock
//   reset         in   1  synchronous, active-high reset
//   number        in   4  decoded key code, meaningful while buttonPressed=1
//   buttonPressed in   1  raw key-down indication (already registered upstream)
//   keyCode       out  4  last accepted key code, held between events
//   keyValid      out  1  one-cycle pulse when a new key is accepted
//   keyHeld       out  1  high from acceptance until the release is accepted
module key_debounce #(
  parameter int DEBOUNCE_COUNT = 20,
  parameter int RELEASE_COUNT  = 20,
  parameter int CNT_WIDTH      = 5
) (
  input  logic       clock1000,
  input  logic       reset,
  input  logic [3:0] number,
  input  logic       buttonPressed,
  output logic [3:0] keyCode,
  output logic       keyValid,
  output logic       keyHeld
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] PRESS_CNT = 2'd1;
  localparam logic [1:0] HELD      = 2'd2;
  localparam logic [1:0] REL_CNT   = 2'd3;

  // The counter holds the number of samples already seen; the sample that
  // completes a run arrives while the counter still equals count-1.
  localparam logic [CNT_WIDTH-1:0] PRESS_LAST   = CNT_WIDTH'(DEBOUNCE_COUNT - 1);
  localparam logic [CNT_WIDTH-1:0] RELEASE_LAST = CNT_WIDTH'(RELEASE_COUNT - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE      = CNT_WIDTH'(1);

  logic [1:0]           state;
  logic [CNT_WIDTH-1:0] cnt;
  logic [3:0]           candidate;

  // Single FSM with registered outputs. keyValid defaults low every cycle so
  // it can only ever be a one-cycle pulse on the acceptance edge.
  always_ff @(posedge clock1000) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      candidate <= 4'h0;
      keyCode   <= 4'h0;
      keyValid  <= 1'b0;
      keyHeld   <= 1'b0;
    end else begin
      keyValid <= 1'b0;
      case (state)
        IDLE: begin
          if (buttonPressed) begin
            candidate <= number;
            if (DEBOUNCE_COUNT == 1) begin
              // A single sample is enough: accept on this very edge.
              keyCode  <= number;
              keyValid <= 1'b1;
              keyHeld  <= 1'b1;
              cnt      <= '0;
              state    <= HELD;
            end else begin
              cnt   <= CNT_ONE;
              state <= PRESS_CNT;
            end
          end
        end

        PRESS_CNT: begin
          if (!buttonPressed) begin
            cnt   <= '0;
            state <= IDLE;
          end else if (number != candidate) begin
            // A different key restarts the run with the new code.
            candidate <= number;
            cnt       <= CNT_ONE;
          end else if (cnt == PRESS_LAST) begin
            keyCode  <= candidate;
            keyValid <= 1'b1;
            keyHeld  <= 1'b1;
            cnt      <= '0;
            state    <= HELD;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        HELD: begin
          // Any key activity while held is ignored; only a low sample matters.
          if (!buttonPressed) begin
            if (RELEASE_COUNT == 1) begin
              keyHeld <= 1'b0;
              cnt     <= '0;
              state   <= IDLE;
            end else begin
              cnt   <= CNT_ONE;
              state <= REL_CNT;
            end
          end
        end

        REL_CNT: begin
          if (buttonPressed) begin
            // Release glitch: back to held without a new event.
            cnt   <= '0;
            state <= HELD;
          end else if (cnt == RELEASE_LAST) begin
            keyHeld <= 1'b0;
            cnt     <= '0;
            state   <= IDLE;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        default: begin
          cnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce
//   Directed bench for key_debounce with default parameters (20/20/5).
//   Inputs change only between clock edges; outputs are read 1 time unit
//   after each rising edge, so the values seen reflect that edge's sample.
module tb_key_debounce;

  logic       clock1000;
  logic       reset;
  logic [3:0] number;
  logic       buttonPressed;
  logic [3:0] keyCode;
  logic       keyValid;
  logic       keyHeld;

  int total;
  int bad;
  int pulses;
  int firstPulse;

  key_debounce dut (
    .clock1000     (clock1000),
    .reset         (reset),
    .number        (number),
    .buttonPressed (buttonPressed),
    .keyCode       (keyCode),
    .keyValid      (keyValid),
    .keyHeld       (keyHeld)
  );

  initial clock1000 = 1'b0;
  always #5 clock1000 = ~clock1000;

  // Every comparison funnels through here.
  task automatic checkOutput(input string tag, input int observed, input int expected);
    total = total + 1;
    if (observed != expected) begin
      bad = bad + 1;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Hold the given inputs for n edges, counting keyValid pulses and noting
  // the 1-based edge index of the first pulse (0 if none).
  task automatic applyStimulus(input int n, input logic bp, input logic [3:0] num);
    pulses     = 0;
    firstPulse = 0;
    buttonPressed = bp;
    number        = num;
    for (int i = 1; i <= n; i++) begin
      @(posedge clock1000);
      #1;
      if (keyValid) begin
        pulses = pulses + 1;
        if (firstPulse == 0) firstPulse = i;
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    number = 4'h0;
    buttonPressed = 1'b0;
    applyStimulus(2, 1'b0, 4'h0);
    checkOutput("reset_keyCode", keyCode, 0);
    checkOutput("reset_keyValid", keyValid, 0);
    checkOutput("reset_keyHeld", keyHeld, 0);
    reset = 1'b0;
    applyStimulus(3, 1'b0, 4'h0);
    checkOutput("idle_pulses", pulses, 0);

    // 1. Clean press of 5 for 40 cycles, then release.
    applyStimulus(40, 1'b1, 4'h5);
    checkOutput("t1_pulses", pulses, 1);
    checkOutput("t1_first", firstPulse, 20);
    checkOutput("t1_code", keyCode, 5);
    checkOutput("t1_held", keyHeld, 1);
    applyStimulus(19, 1'b0, 4'h5);
    checkOutput("t1_held_rel19", keyHeld, 1);
    applyStimulus(1, 1'b0, 4'h5);
    checkOutput("t1_held_rel20", keyHeld, 0);
    checkOutput("t1_rel_pulses", pulses, 0);

    // 2. Bounce 1,0,1,1,0 then steady 9.
    applyStimulus(1, 1'b1, 4'h9);
    checkOutput("t2_b0", pulses, 0);
    applyStimulus(1, 1'b0, 4'h9);
    applyStimulus(2, 1'b1, 4'h9);
    checkOutput("t2_b2", pulses, 0);
    applyStimulus(1, 1'b0, 4'h9);
    applyStimulus(25, 1'b1, 4'h9);
    checkOutput("t2_pulses", pulses, 1);
    checkOutput("t2_first", firstPulse, 20);
    checkOutput("t2_code", keyCode, 9);
    applyStimulus(20, 1'b0, 4'h9);
    checkOutput("t2_released", keyHeld, 0);

    // 3. Key change mid-debounce: 3 for 10, then 7 steady.
    applyStimulus(10, 1'b1, 4'h3);
    checkOutput("t3_no3", pulses, 0);
    checkOutput("t3_code_kept", keyCode, 9);
    applyStimulus(25, 1'b1, 4'h7);
    checkOutput("t3_pulses", pulses, 1);
    checkOutput("t3_first", firstPulse, 20);
    checkOutput("t3_code", keyCode, 7);
    applyStimulus(20, 1'b0, 4'h7);
    checkOutput("t3_released", keyHeld, 0);

    // 4. Release glitch after accepting 0xB.
    applyStimulus(20, 1'b1, 4'hB);
    checkOutput("t4_first", firstPulse, 20);
    checkOutput("t4_code", keyCode, 11);
    applyStimulus(10, 1'b0, 4'hB);
    checkOutput("t4_low10_held", keyHeld, 1);
    applyStimulus(1, 1'b1, 4'hB);
    checkOutput("t4_glitch_pulses", pulses, 0);
    applyStimulus(19, 1'b0, 4'hB);
    checkOutput("t4_low19_held", keyHeld, 1);
    checkOutput("t4_low19_pulses", pulses, 0);
    applyStimulus(1, 1'b0, 4'hB);
    checkOutput("t4_low20_held", keyHeld, 0);
    applyStimulus(5, 1'b0, 4'hB);
    checkOutput("t4_tail_pulses", pulses, 0);

    // 5. Held-key change: accept 4, then hold 8 for 50 cycles.
    applyStimulus(20, 1'b1, 4'h4);
    checkOutput("t5_first", firstPulse, 20);
    applyStimulus(50, 1'b1, 4'h8);
    checkOutput("t5_no8", pulses, 0);
    checkOutput("t5_code", keyCode, 4);
    checkOutput("t5_held", keyHeld, 1);
    applyStimulus(20, 1'b0, 4'h8);
    checkOutput("t5_released", keyHeld, 0);

    // 6. Reset at count 15 of a press of 0xF, key kept down throughout.
    applyStimulus(15, 1'b1, 4'hF);
    checkOutput("t6_pre_pulses", pulses, 0);
    reset = 1'b1;
    applyStimulus(1, 1'b1, 4'hF);
    checkOutput("t6_rst_valid", keyValid, 0);
    checkOutput("t6_rst_code", keyCode, 0);
    checkOutput("t6_rst_held", keyHeld, 0);
    reset = 1'b0;
    applyStimulus(19, 1'b1, 4'hF);
    checkOutput("t6_post19_pulses", pulses, 0);
    checkOutput("t6_post19_held", keyHeld, 0);
    applyStimulus(1, 1'b1, 4'hF);
    checkOutput("t6_post20_pulses", pulses, 1);
    checkOutput("t6_code", keyCode, 15);
    checkOutput("t6_held", keyHeld, 1);
    applyStimulus(1, 1'b1, 4'hF);
    checkOutput("t6_pulse_ends", keyValid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
